// File: rtl/bayer_quad_proc_if.sv
// ---------------------------------------------------------------------------
// bayer_quad_proc_if
// Bundles the raw Bayer input stream and the processed pixel output stream of
// bayer_quad_proc so both sides can be passed around as one port.
//
// Signals:
//   i_data   raw Bayer pixel from data capture
//   i_dval   i_data valid this cycle
//   i_sof    start-of-frame pulse, restarts position counters, latches i_mode
//   i_mode   00 RGB, 01 gray, 10 raw, 11 behaves as 00
//   o_r/o_g/o_b  output colour
//   o_gray   luma, or raw pixel in raw mode
//   o_valid  single-cycle strobe marking valid outputs
//   o_x/o_y  output column / row
//
// Modports:
//   slave  - the processing block (consumes i_*, produces o_*)
//   master - the pixel source / sink around it
// ---------------------------------------------------------------------------
interface bayer_quad_proc_if #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 640,
    parameter int Y_W    = 16
);
    localparam int X_W = $clog2(LINE_W);

    logic [DATA_W-1:0] i_data;
    logic              i_dval;
    logic              i_sof;
    logic [1:0]        i_mode;

    logic [DATA_W-1:0] o_r;
    logic [DATA_W-1:0] o_g;
    logic [DATA_W-1:0] o_b;
    logic [DATA_W-1:0] o_gray;
    logic              o_valid;
    logic [X_W-1:0]    o_x;
    logic [Y_W-1:0]    o_y;

    modport slave (
        input  i_data, i_dval, i_sof, i_mode,
        output o_r, o_g, o_b, o_gray, o_valid, o_x, o_y
    );

    modport master (
        output i_data, i_dval, i_sof, i_mode,
        input  o_r, o_g, o_b, o_gray, o_valid, o_x, o_y
    );
endinterface

// File: rtl/bayer_quad_proc.sv
// ---------------------------------------------------------------------------
// bayer_quad_proc
// Buffers one line of raw GRBG Bayer pixels and turns each completed 2x2 quad
// into one RGB pixel plus a luma value. A per-frame mode selects RGB output,
// grayscale output (luma copied onto all three colours) or raw passthrough of
// every input pixel without decimation.
//
// Ports:
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   bus    bayer_quad_proc_if.slave: i_data/i_dval/i_sof/i_mode in,
//          o_r/o_g/o_b/o_gray/o_valid/o_x/o_y out
//
// Quad layout (even rows G R, odd rows B G). The quad completes on the odd
// column of an odd row; at that moment:
//   tap A  (line buffer, same column, row above) = R
//   P_d    (previous input pixel)                = B
//   A_d    (previous tap A, row above)           = G on the even row
//   i_data                                        = G on the odd row
// ---------------------------------------------------------------------------
module bayer_quad_proc #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 640,
    parameter int Y_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    bayer_quad_proc_if.slave    bus
);
    localparam int             X_W    = $clog2(LINE_W);
    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);

    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [1:0]        mode_q;

    logic [X_W-1:0]    x_eff;
    logic [Y_W-1:0]    y_eff;
    logic [1:0]        mode_eff;
    logic [X_W-1:0]    x_next;
    logic [Y_W-1:0]    y_next;

    logic [DATA_W-1:0] line_mem [LINE_W];
    logic [DATA_W-1:0] tap_a;
    logic [DATA_W-1:0] p_d;
    logic [DATA_W-1:0] a_d;

    logic              raw_sel;
    logic              gray_sel;
    logic              quad_done;

    logic [DATA_W:0]   g_sum;
    logic [DATA_W-1:0] g_val;
    logic [DATA_W+1:0] gray_sum;
    logic [DATA_W-1:0] gray_val;

    // A start-of-frame pulse takes effect in its own cycle: a sample that
    // arrives together with i_sof is already pixel (0,0) and already uses
    // the newly requested mode, so every downstream decision looks at these
    // "effective" values rather than at the registered ones.
    always_comb begin
        x_eff    = x_cnt;
        y_eff    = y_cnt;
        mode_eff = mode_q;
        if (bus.i_sof) begin
            x_eff    = '0;
            y_eff    = '0;
            mode_eff = bus.i_mode;
        end
        raw_sel   = (mode_eff == 2'b10);
        gray_sel  = (mode_eff == 2'b01);
        quad_done = bus.i_dval && x_eff[0] && y_eff[0];
    end

    // Tap A: asynchronous read of the line buffer at the current column,
    // which still holds the pixel from the row above because the write of
    // this sample only lands at the clock edge.
    assign tap_a = line_mem[x_eff];

    // Colour reconstruction. Sums are one and two bits wider than a pixel so
    // that full-scale inputs average back to full scale instead of wrapping.
    always_comb begin
        g_sum    = {1'b0, a_d} + {1'b0, bus.i_data};
        g_val    = DATA_W'(g_sum >> 1);
        gray_sum = {2'b00, tap_a} + {1'b0, g_val, 1'b0} + {2'b00, p_d};
        gray_val = DATA_W'(gray_sum >> 2);
    end

    // Position counter next-state: column wraps at the end of a line and
    // bumps the row, which sticks at all-ones instead of rolling over.
    // With no valid sample, a lone i_sof still clears both counters.
    always_comb begin
        x_next = x_cnt;
        y_next = y_cnt;
        if (bus.i_dval) begin
            if (x_eff == X_LAST) begin
                x_next = '0;
                y_next = (&y_eff) ? y_eff : y_eff + 1'b1;
            end else begin
                x_next = x_eff + 1'b1;
                y_next = y_eff;
            end
        end else if (bus.i_sof) begin
            x_next = '0;
            y_next = '0;
        end
    end

    // Counters, frame mode and the one-sample delay registers. Everything
    // here freezes while i_dval is low, so input gaps are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            mode_q <= 2'b00;
            p_d    <= '0;
            a_d    <= '0;
        end else begin
            x_cnt <= x_next;
            y_cnt <= y_next;
            if (bus.i_sof) begin
                mode_q <= bus.i_mode;
            end
            if (bus.i_dval) begin
                p_d <= bus.i_data;
                a_d <= tap_a;
            end
        end
    end

    // Line buffer storage. Not reset: row 0 never completes a quad, so
    // whatever it holds before the first line is rewritten is never used.
    always_ff @(posedge clk) begin
        if (bus.i_dval) begin
            line_mem[x_eff] <= bus.i_data;
        end
    end

    // Output register. o_valid is a one-cycle strobe; the data fields keep
    // their last value between strobes. Raw mode forwards every sample with
    // full-resolution coordinates; the quad modes report quad coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_r     <= '0;
            bus.o_g     <= '0;
            bus.o_b     <= '0;
            bus.o_gray  <= '0;
            bus.o_valid <= 1'b0;
            bus.o_x     <= '0;
            bus.o_y     <= '0;
        end else begin
            bus.o_valid <= 1'b0;
            if (raw_sel) begin
                if (bus.i_dval) begin
                    bus.o_r     <= '0;
                    bus.o_g     <= '0;
                    bus.o_b     <= '0;
                    bus.o_gray  <= bus.i_data;
                    bus.o_x     <= x_eff;
                    bus.o_y     <= y_eff;
                    bus.o_valid <= 1'b1;
                end
            end else if (quad_done) begin
                if (gray_sel) begin
                    bus.o_r <= gray_val;
                    bus.o_g <= gray_val;
                    bus.o_b <= gray_val;
                end else begin
                    bus.o_r <= tap_a;
                    bus.o_g <= g_val;
                    bus.o_b <= p_d;
                end
                bus.o_gray  <= gray_val;
                bus.o_x     <= x_eff >> 1;
                bus.o_y     <= y_eff >> 1;
                bus.o_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bayer_quad_proc.sv
// ---------------------------------------------------------------------------
// tb_bayer_quad_proc
// Directed testbench for bayer_quad_proc with an 8-pixel line. Stimulus tasks
// drive samples and push hand-computed expected outputs (including the cycle
// on which each must appear) into a scoreboard queue; an independent monitor
// pops and compares whenever the DUT strobes o_valid.
// ---------------------------------------------------------------------------
module tb_bayer_quad_proc;
    localparam int DATA_W = 12;
    localparam int LINE_W = 8;
    localparam int Y_W    = 16;
    localparam int X_W    = $clog2(LINE_W);

    typedef struct {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] gray;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        int                cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   drive_cycle;
    int   check_count;
    int   pass_count;
    exp_t sb[$];

    bayer_quad_proc_if #(.DATA_W(DATA_W), .LINE_W(LINE_W), .Y_W(Y_W)) bus ();

    bayer_quad_proc #(.DATA_W(DATA_W), .LINE_W(LINE_W), .Y_W(Y_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock and a cycle counter used for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_dval = 1'b0;
            bus.i_sof  = 1'b0;
        end
    endtask

    // Drive one valid sample, optionally preceded by a random idle gap.
    task automatic apply_stimulus(input logic [DATA_W-1:0] data, input logic sof,
                                  input logic [1:0] mode, input int gap_max);
        if (gap_max > 0) begin
            idle(int'($urandom_range(0, gap_max)));
        end
        @(negedge clk);
        bus.i_data  = data;
        bus.i_dval  = 1'b1;
        bus.i_sof   = sof;
        bus.i_mode  = mode;
        drive_cycle = cycle;
    endtask

    // Expected output for the sample just driven: visible one cycle later.
    task automatic expect_out(input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] g,
                              input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] gray,
                              input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        exp_t e;
        e.r = r; e.g = g; e.b = b; e.gray = gray; e.x = x; e.y = y;
        e.cyc = drive_cycle + 1;
        sb.push_back(e);
    endtask

    // One even row (g0 r0 ...) then up to row1_len pixels of an odd row
    // (b1 g1 ...); every odd column of the odd row completes a quad.
    task automatic send_row_pair(input logic [DATA_W-1:0] g0, input logic [DATA_W-1:0] r0,
                                 input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] g1,
                                 input logic sof_first, input logic [1:0] mode0,
                                 input logic [1:0] mode1, input int gap, input int row1_len,
                                 input logic [DATA_W-1:0] er, input logic [DATA_W-1:0] eg,
                                 input logic [DATA_W-1:0] eb, input logic [DATA_W-1:0] egray,
                                 input logic [Y_W-1:0] ey);
        for (int x = 0; x < LINE_W; x++) begin
            apply_stimulus((x % 2 == 0) ? g0 : r0, sof_first && (x == 0), mode0, gap);
        end
        for (int x = 0; x < row1_len; x++) begin
            apply_stimulus((x % 2 == 0) ? b1 : g1, 1'b0, mode1, gap);
            if (x % 2 == 1) begin
                expect_out(er, eg, eb, egray, X_W'(x / 2), ey);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        idle(1);
        while (sb.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        check_output({"drain_", name}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_r"},     bus.o_r, 0);
        check_output({name, "_g"},     bus.o_g, 0);
        check_output({name, "_b"},     bus.o_b, 0);
        check_output({name, "_gray"},  bus.o_gray, 0);
        check_output({name, "_valid"}, bus.o_valid, 0);
        check_output({name, "_x"},     bus.o_x, 0);
        check_output({name, "_y"},     bus.o_y, 0);
    endtask

    // Monitor: every o_valid strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("out_r",    bus.o_r, e.r);
                check_output("out_g",    bus.o_g, e.g);
                check_output("out_b",    bus.o_b, e.b);
                check_output("out_gray", bus.o_gray, e.gray);
                check_output("out_x",    bus.o_x, e.x);
                check_output("out_y",    bus.o_y, e.y);
                check_output("latency",  cycle, e.cyc);
            end
        end
    end

    initial begin
        check_count = 0;
        pass_count  = 0;
        drive_cycle = 0;
        rst_n       = 1'b0;
        bus.i_data  = '0;
        bus.i_dval  = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_mode  = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // RGB: G100/R200 over B50/G300 -> R200 G200 B50 gray162 (650>>2),
        // then G10/R20 over B30/G40 -> R20 G25 B30 gray25 (100>>2) on o_y=1.
        send_row_pair(100, 200, 50, 300, 1'b1, 2'b00, 2'b00, 0, LINE_W, 200, 200, 50, 162, 0);
        send_row_pair(10, 20, 30, 40, 1'b0, 2'b00, 2'b00, 0, LINE_W, 20, 25, 30, 25, 1);
        wait_drain("rgb");
        idle(4);
        check_output("hold_gray", bus.o_gray, 25);
        check_output("hold_x", bus.o_x, 3);
        check_output("hold_y", bus.o_y, 1);

        // Gray, with i_mode switched to raw on the odd row but no i_sof
        send_row_pair(100, 200, 50, 300, 1'b1, 2'b01, 2'b10, 0, LINE_W, 162, 162, 162, 162, 0);
        wait_drain("gray");

        // Saturation: full-scale everywhere must stay full-scale
        send_row_pair(4095, 4095, 4095, 4095, 1'b1, 2'b00, 2'b00, 0, LINE_W,
                      4095, 4095, 4095, 4095, 0);
        wait_drain("sat");

        // Gaps and mid-line restart (mode 11 behaves as RGB): row 1 stops
        // after x=4, the restart sample arrives where x=5 would be.
        send_row_pair(100, 200, 50, 300, 1'b1, 2'b11, 2'b11, 3, 5, 200, 200, 50, 162, 0);
        send_row_pair(100, 200, 50, 300, 1'b1, 2'b11, 2'b11, 3, LINE_W, 200, 200, 50, 162, 0);
        wait_drain("gaps");

        // Raw: ramp 0..15 over two rows, every sample forwarded
        for (int i = 0; i < 2 * LINE_W; i++) begin
            apply_stimulus(DATA_W'(i), i == 0, 2'b10, 0);
            expect_out(0, 0, 0, DATA_W'(i), X_W'(i % LINE_W), Y_W'(i / LINE_W));
        end
        wait_drain("raw");

        // Reset mid-stream: a gray frame is interrupted after two quads
        send_row_pair(100, 200, 50, 300, 1'b1, 2'b01, 2'b01, 0, 4, 162, 162, 162, 162, 0);
        apply_stimulus(50, 1'b0, 2'b01, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        idle(2);
        rst_n = 1'b1;

        // Without i_sof counting restarts at (0,0) and mode is back to RGB;
        // the requested raw mode is ignored since no i_sof accompanies it.
        send_row_pair(100, 200, 50, 300, 1'b0, 2'b10, 2'b10, 0, LINE_W, 200, 200, 50, 162, 0);
        wait_drain("after_reset");
        idle(3);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/bayer_quad_proc.md
# bayer_quad_proc

Parametrised successor to the single-tap Bayer line buffer in the camera image path. It accepts raw Bayer pixels from data capture, buffers one line internally, and assembles each 2x2 GRBG quad into one RGB pixel, or into a grayscale or raw-passthrough stream. Output selection is per-frame and set by a mode input. Output feeds the SDRAM write-side packing logic.

## Interface
- DATA_W, 12, raw pixel width
- LINE_W, 640, pixels per input line; even, >= 4
- Y_W, 16, line counter width
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- i_data  in  DATA_W  raw Bayer pixel
- i_dval  in  1  i_data valid this cycle
- i_sof  in  1  start-of-frame pulse; resets position counters
- i_mode  in  2  00 RGB, 01 gray, 10 raw, 11 treated as 00; sampled at i_sof
- o_r, o_g, o_b  out  DATA_W each  output colour
- o_gray  out  DATA_W  luma, or raw pixel in raw mode
- o_valid  out  1  outputs valid, single-cycle strobe
- o_x  out  $clog2(LINE_W)  output column
- o_y  out  Y_W  output row

## Operation
- **Position counters:**
  - x_cnt runs 0..LINE_W-1 and advances only on i_dval.
  - On wrap, x_cnt returns to 0 and y_cnt increments. y_cnt saturates at all-ones.
  - i_sof zeroes both counters and latches i_mode into mode_q.
  - If i_sof and i_dval are high in the same cycle, that sample is pixel (0,0).
- **Line buffer:**
  - LINE_W x DATA_W storage, addressed by x_cnt.
  - Read-before-write on i_dval, so the read (tap A) returns the pixel from the line above at the same column.
  - Storage is not reset. Row 0 never produces output, so its contents are don't-care.
- **Delay registers:** P_d holds the previous i_data and A_d holds the previous tap A. Both load only on i_dval.
- **Quad pattern (GRBG):** even rows are G R; odd rows are B G.
- **Quad complete** when i_dval=1 and x_cnt and y_cnt are both odd. Then:
  - R = A
  - B = P_d
  - G = (A_d + i_data) >> 1, with a DATA_W+1-bit sum
  - gray = (R + 2G + B) >> 2, with a DATA_W+2-bit sum and truncation
- **Mode 00 (RGB):** on quad complete, register R/G/B/gray, o_x = x_cnt>>1, o_y = y_cnt>>1, and pulse o_valid.
- **Mode 01 (gray):** as mode 00, but o_r = o_g = o_b = gray.
- **Mode 10 (raw):** on every i_dval, o_gray = i_data, o_r/o_g/o_b = 0, o_x = x_cnt, o_y = y_cnt, and pulse o_valid. No decimation.
- **Holding:** data outputs hold their last value when o_valid=0.
- **i_sof mid-line:** the partial line is discarded; the counters restart and the buffer is not cleared.

## Timing
- **Reset:** all outputs 0, o_valid 0, counters 0, mode_q 00, P_d/A_d 0.
- **Latency:** exactly 1 cycle from the qualifying i_dval sample to o_valid.
- **Throughput:**
  - Modes 00/01: one output per 4 inputs, LINE_W/2 outputs per odd row.
  - Mode 10: one output per input.
- **Backpressure:** none. i_dval gaps of any length freeze all state.
- **Mode changes:** a change in i_mode without i_sof has no effect.
- **Reset mid-frame:** all state clears immediately. The next valid frame requires i_sof; without it, counting restarts at (0,0).

## Test plan
- **Reset:** assert rst_n low mid-stream -> all outputs 0 in the same cycle; no o_valid until a new odd quad completes.
- **RGB (LINE_W=8, mode 00):**
  - Stimulus: row 0 = G100, R200 alternating; row 1 = B50, G300 alternating; i_dval continuous.
  - Required: 4 o_valid pulses during row 1 at o_x 0..3, o_y 0, each with o_r=200, o_g=200, o_b=50, o_gray=162.
  - Each pulse occurs 1 cycle after the odd-x sample.
- **Gray:** same stimulus with i_mode=01 latched at i_sof -> o_r = o_g = o_b = o_gray = 162.
- **Saturation:** all pixels 4095 in mode 00 -> o_r/o_g/o_b/o_gray = 4095; no wrap.
- **Gaps and restart:**
  - Stimulus: random i_dval gaps; then i_sof at x=5 of row 1.
  - Required: results identical to the gap-free run; no output from the discarded partial line; the next output appears at o_x=0, o_y=0 after rows 0/1 are re-sent.
- **Raw:** i_mode=10 with a ramp 0..15 over two rows -> 16 o_valid pulses; o_gray equals the ramp; o_x = 0..7 on each row; o_y = 0 then 1.
